// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single regfile write port: one holding buffer per
// source, oldest buffered write drains first, plus decode hazard-check lookups.
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_valid_i,
  output logic [NUM_SRC-1:0]             src_ready_o,
  input  logic [NUM_SRC-1:0][4:0]        src_rd_s_i,
  input  logic [NUM_SRC-1:0][DATA_W-1:0] src_rd_v_i,
  output logic                           regf_we_o,
  output logic [4:0]                     rd_s_o,
  output logic [DATA_W-1:0]              rd_v_o,
  output logic [NUM_SRC-1:0]             grant_o,
  input  logic [4:0]                     chk_rs1_s_i,
  input  logic [4:0]                     chk_rs2_s_i,
  output logic                           chk_rs1_busy_o,
  output logic                           chk_rs2_busy_o
);

  logic [NUM_SRC-1:0]                     full_q, full_d;
  logic [NUM_SRC-1:0][4:0]                rd_q, rd_d;
  logic [NUM_SRC-1:0][DATA_W-1:0]         val_q, val_d;
  // older_q[i][j]: entry i was accepted before entry j (meaningful only when both are full)
  logic [NUM_SRC-1:0][NUM_SRC-1:0]        older_q, older_d;

  logic [NUM_SRC-1:0]                     grant;
  logic [NUM_SRC-1:0]                     hs;
  logic [NUM_SRC-1:0]                     acc;

  always_comb begin
    logic found;
    logic oldest;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      oldest = full_q[i];
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j != i && full_q[j] && !older_q[i][j]) oldest = 1'b0;
      end
      if (oldest && !found && !rst) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign src_ready_o = rst ? '0 : (~full_q | grant);
  assign hs          = src_valid_i & src_ready_o;
  assign grant_o     = grant;
  assign regf_we_o   = |grant;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      acc[i] = hs[i] && (src_rd_s_i[i] != 5'd0);
    end
  end

  always_comb begin
    full_d  = '0;
    rd_d    = rd_q;
    val_d   = val_q;
    older_d = '0;
    if (!rst) begin
      full_d = acc | (full_q & ~grant);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (acc[i]) begin
          rd_d[i]  = src_rd_s_i[i];
          val_d[i] = src_rd_v_i[i];
        end
        // A newly accepted entry is younger than all survivors; same-cycle ties go by index.
        for (int j = 0; j < NUM_SRC; j++) begin
          if (i == j)                 older_d[i][j] = 1'b0;
          else if (acc[i] && acc[j])  older_d[i][j] = (i < j);
          else if (acc[i])            older_d[i][j] = 1'b0;
          else if (acc[j])            older_d[i][j] = 1'b1;
          else                        older_d[i][j] = older_q[i][j];
        end
      end
    end
  end

  always_comb begin
    rd_s_o = '0;
    rd_v_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        rd_s_o = rd_q[i];
        rd_v_o = val_q[i];
      end
    end
  end

  always_comb begin
    chk_rs1_busy_o = 1'b0;
    chk_rs2_busy_o = 1'b0;
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (full_q[i] && chk_rs1_s_i != 5'd0 && rd_q[i] == chk_rs1_s_i) chk_rs1_busy_o = 1'b1;
        if (full_q[i] && chk_rs2_s_i != 5'd0 && rd_q[i] == chk_rs2_s_i) chk_rs2_busy_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    full_q  <= full_d;
    rd_q    <= rd_d;
    val_q   <= val_d;
    older_q <= older_d;
  end

endmodule
